// File: rtl/bin_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3). One conversion per start/done
// handshake, with a leading-zero blank mask and an overflow flag for narrow digit counts.
module bin_bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic               sticky_q, sticky_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [DIGITS-1:0]  blank_q, blank_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   adj;

  // Every digit >= 5 gets +3 in parallel; 4-bit add, a digit never exceeds 9 here.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // A digit is blanked when it and every digit above it are zero; ones digit always shown.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] s);
    logic [DIGITS-1:0] m;
    logic              all_zero;
    m        = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (s[4*i +: 4] == 4'd0);
      m[i]     = all_zero;
    end
    m[0] = 1'b0;
    return m;
  endfunction

  assign adj = add3_digits(scratch_q);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    sticky_d  = sticky_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    blank_d   = blank_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = binary;
          scratch_d = '0;
          sticky_d  = 1'b0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // A bit leaving the top digit means the value needs more than DIGITS digits.
        scratch_d = {adj[BCD_W-2:0], shift_q[BIN_W-1]};
        shift_d   = {shift_q[BIN_W-2:0], 1'b0};
        sticky_d  = sticky_q | adj[BCD_W-1];
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = DONE;
      end
      DONE: begin
        bcd_d   = scratch_q;
        blank_d = blank_mask(scratch_q);
        ovf_d   = sticky_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      sticky_q  <= 1'b0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      blank_q   <= BLANK_RST;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      blank_q   <= blank_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  // Busy drops on the edge that raises done, so a held start restarts right away.
  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign bcd   = bcd_q;
  assign blank = blank_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Directed bench for bin_bcd_seq: three parameter sets driven from one clock,
// a vector table for conversions, plus handshake, reset-abort and back-to-back sequences.
module tb_bin_bcd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // a: BIN_W=8 DIGITS=3, b: BIN_W=16 DIGITS=5, c: BIN_W=8 DIGITS=2
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [7:0]  bin_a = '0, bin_c = '0;
  logic [15:0] bin_b = '0;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c, ovf_a, ovf_b, ovf_c;
  logic [11:0] bcd_a;
  logic [19:0] bcd_b;
  logic [7:0]  bcd_c;
  logic [2:0]  blank_a;
  logic [4:0]  blank_b;
  logic [1:0]  blank_c;

  bin_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .binary(bin_a), .busy(busy_a),
    .done(done_a), .bcd(bcd_a), .blank(blank_a), .ovf(ovf_a));
  bin_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .binary(bin_b), .busy(busy_b),
    .done(done_b), .bcd(bcd_b), .blank(blank_b), .ovf(ovf_b));
  bin_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .binary(bin_c), .busy(busy_c),
    .done(done_c), .bcd(bcd_c), .blank(blank_c), .ovf(ovf_c));

  int checks = 0;
  int errors = 0;
  int ndone_a = 0;

  always @(negedge clk) if (done_a) ndone_a++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic get_done(input int which);
    case (which)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  // Drive one start pulse, count edges from the accepting edge to done, return outputs.
  task automatic run_conv(input int which, input logic [15:0] v, output int lat,
                          output logic [19:0] r_bcd, output logic [4:0] r_blank,
                          output logic r_ovf);
    @(negedge clk);
    case (which)
      0: begin start_a = 1'b1; bin_a = v[7:0]; end
      1: begin start_b = 1'b1; bin_b = v; end
      default: begin start_c = 1'b1; bin_c = v[7:0]; end
    endcase
    @(posedge clk);
    #1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (get_done(which)) break;
    end
    case (which)
      0: begin r_bcd = {8'h0, bcd_a}; r_blank = {2'b0, blank_a}; r_ovf = ovf_a; end
      1: begin r_bcd = bcd_b; r_blank = blank_b; r_ovf = ovf_b; end
      default: begin r_bcd = {12'h0, bcd_c}; r_blank = {3'b0, blank_c}; r_ovf = ovf_c; end
    endcase
  endtask

  typedef struct {
    int          which;
    logic [15:0] v;
    logic [19:0] bcd;
    logic [4:0]  blank;
    logic        ovf;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int          lat;
    logic [19:0] r_bcd;
    logic [4:0]  r_blank;
    logic        r_ovf;

    vecs[0]  = '{0, 16'd145,   20'h00145, 5'b00000, 1'b0};
    vecs[1]  = '{0, 16'd0,     20'h00000, 5'b00110, 1'b0};
    vecs[2]  = '{0, 16'd7,     20'h00007, 5'b00110, 1'b0};
    vecs[3]  = '{0, 16'd255,   20'h00255, 5'b00000, 1'b0};
    vecs[4]  = '{0, 16'd37,    20'h00037, 5'b00100, 1'b0};
    vecs[5]  = '{1, 16'd65535, 20'h65535, 5'b00000, 1'b0};
    vecs[6]  = '{1, 16'd0,     20'h00000, 5'b11110, 1'b0};
    vecs[7]  = '{1, 16'd1000,  20'h01000, 5'b10000, 1'b0};
    vecs[8]  = '{1, 16'd9,     20'h00009, 5'b11110, 1'b0};
    vecs[9]  = '{2, 16'd145,   20'h00045, 5'b00000, 1'b1};
    vecs[10] = '{2, 16'd99,    20'h00099, 5'b00000, 1'b0};
    vecs[11] = '{2, 16'd255,   20'h00055, 5'b00000, 1'b1};
    vecs[12] = '{2, 16'd5,     20'h00005, 5'b00010, 1'b0};
    vecs[13] = '{2, 16'd100,   20'h00000, 5'b00010, 1'b1};

    // Reset state
    #12;
    chk("rst_busy", {31'b0, busy_a}, 32'd0);
    chk("rst_done", {31'b0, done_a}, 32'd0);
    chk("rst_bcd", {20'b0, bcd_a}, 32'd0);
    chk("rst_blank_a", {29'b0, blank_a}, 32'b110);
    chk("rst_blank_b", {27'b0, blank_b}, 32'b11110);
    chk("rst_ovf", {31'b0, ovf_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_conv(vecs[i].which, vecs[i].v, lat, r_bcd, r_blank, r_ovf);
      chk($sformatf("vec%0d_lat", i), lat, (vecs[i].which == 1) ? 32'd17 : 32'd9);
      chk($sformatf("vec%0d_bcd", i), {12'b0, r_bcd}, {12'b0, vecs[i].bcd});
      chk($sformatf("vec%0d_blank", i), {27'b0, r_blank}, {27'b0, vecs[i].blank});
      chk($sformatf("vec%0d_ovf", i), {31'b0, r_ovf}, {31'b0, vecs[i].ovf});
    end

    // start while busy is ignored
    @(negedge clk);
    start_a = 1'b1; bin_a = 8'd37;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    ndone_a = 0;
    chk("busy_after_accept", {31'b0, busy_a}, 32'd1);
    @(negedge clk);
    start_a = 1'b1; bin_a = 8'd200;
    @(negedge clk);
    start_a = 1'b0;
    repeat (14) @(negedge clk);
    #1;
    chk("busy_ignore_ndone", ndone_a, 32'd1);
    chk("busy_ignore_bcd", {20'b0, bcd_a}, 32'h037);
    chk("busy_ignore_blank", {29'b0, blank_a}, 32'b100);
    chk("busy_ignore_idle", {31'b0, busy_a}, 32'd0);

    // Asynchronous reset in SHIFT cycle 4 aborts without a done pulse
    @(negedge clk);
    start_a = 1'b1; bin_a = 8'd200;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    ndone_a = 0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy_a}, 32'd0);
    chk("arst_bcd", {20'b0, bcd_a}, 32'd0);
    chk("arst_blank", {29'b0, blank_a}, 32'b110);
    chk("arst_done", {31'b0, done_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    chk("arst_no_done", ndone_a, 32'd0);
    run_conv(0, 16'd200, lat, r_bcd, r_blank, r_ovf);
    chk("post_rst_lat", lat, 32'd9);
    chk("post_rst_bcd", {12'b0, r_bcd}, 32'h200);

    // start held high: back-to-back conversions of 1, 2, 3
    @(negedge clk);
    start_a = 1'b1; bin_a = 8'd1;
    @(posedge clk);
    #1;
    chk("b2b_busy0", {31'b0, busy_a}, 32'd1);
    bin_a = 8'd2;
    for (int k = 0; k < 3; k++) begin
      lat = 0;
      while (lat < 100) begin
        @(posedge clk);
        lat++;
        #1;
        if (done_a) break;
      end
      chk($sformatf("b2b%0d_lat", k), lat, 32'd9);
      chk($sformatf("b2b%0d_bcd", k), {20'b0, bcd_a}, k + 1);
      if (k < 2) begin
        @(posedge clk);
        #1;
        chk($sformatf("b2b%0d_restart", k), {31'b0, busy_a}, 32'd1);
        if (k == 0) bin_a = 8'd3;
        else start_a = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
